// File: rtl/uart_pkg.sv
// Shared UART constants and the FIFO entry type.
// UART_RX_FIFO_BREAK_EN adds a break flag to every stored entry.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int FIFO_DEPTH_LOG2 = 4;

`ifdef UART_RX_FIFO_BREAK_EN
  localparam int BREAK_BITS = 1;
  typedef struct packed {
    logic                      brk;
    logic [UART_DATA_BITS-1:0] data;
  } uart_entry_t;
`else
  localparam int BREAK_BITS = 0;
  typedef struct packed {
    logic [UART_DATA_BITS-1:0] data;
  } uart_entry_t;
`endif

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array dual-port memory with a synchronous write port and an asynchronous read port.
// Generic in width and depth, so it can also back a transmit FIFO.
module uart_fifo_mem #(
  parameter int ADDR_BITS = 4,
  parameter int WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: first-word-fall-through read port, fill level,
// sticky overrun and level-threshold irq. Build option: UART_RX_FIFO_BREAK_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rx_valid,
  input  logic [DATA_BITS-1:0]  rx_data,
  input  logic                  rx_break,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_BITS-1:0]  rd_data,
  output logic                  rd_break,
  input  logic                  flush,
  input  logic                  clr_overrun,
  output logic                  overrun,
  output logic [DEPTH_LOG2:0]   level,
  input  logic [DEPTH_LOG2:0]   thr,
  output logic                  irq
);

  localparam int WORD_BITS = DATA_BITS + BREAK_BITS;
  localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [WORD_BITS-1:0]  wr_word, rd_word;
  logic                  full, push, pop, drop;

  assign full     = (level == DEPTH);
  assign rd_valid = (level != '0);
  assign pop      = rd_valid & rd_ready;
  // A full FIFO still accepts a character when the head is popped in the same cycle.
  assign push     = rx_valid & (~full | pop) & ~flush;
  assign drop     = rx_valid & full & ~pop & ~flush;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_BREAK_EN
  assign wr_word  = {rx_break, rx_data};
  assign rd_data  = rd_word[DATA_BITS-1:0];
  assign rd_break = rd_word[DATA_BITS];
`else
  // Without a break bit in storage a break becomes an ordinary all-zero character.
  assign wr_word  = rx_break ? '0 : rx_data;
  assign rd_data  = rd_word;
  assign rd_break = 1'b0;
`endif

  uart_fifo_mem #(
    .ADDR_BITS(DEPTH_LOG2),
    .WIDTH    (WORD_BITS)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(wr_word),
    .raddr(rd_ptr),
    .rdata(rd_word)
  );

  assign irq = (level >= thr) && (thr != '0);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DL    = 4;
  localparam int DB    = 8;
  localparam int DEPTH = 16;

  logic          clk;
  logic          resetn;
  logic          rx_valid;
  logic [DB-1:0] rx_data;
  logic          rx_break;
  logic          rd_ready;
  logic          rd_valid;
  logic [DB-1:0] rd_data;
  logic          rd_break;
  logic          flush;
  logic          clr_overrun;
  logic          overrun;
  logic [DL:0]   level;
  logic [DL:0]   thr;
  logic          irq;

  uart_rx_fifo #(.DEPTH_LOG2(DL), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_break   (rx_break),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_break   (rd_break),
    .flush      (flush),
    .clr_overrun(clr_overrun),
    .overrun    (overrun),
    .level      (level),
    .thr        (thr),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each entry is {break, data}.
  logic [DB:0] exp_q[$];
  logic        exp_ovr;
  int          errors;
  int          checks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Apply the FIFO rules to the model for the edge about to happen.
  task automatic model_edge();
    bit do_pop, is_full;
    logic [DB:0] entry;
    if (!resetn) begin
      exp_q.delete();
      exp_ovr = 1'b0;
      return;
    end
    do_pop  = (exp_q.size() != 0) && rd_ready;
    is_full = (exp_q.size() == DEPTH);
    if (rx_valid && is_full && !do_pop && !flush) exp_ovr = 1'b1;
    else if (clr_overrun)                         exp_ovr = 1'b0;
    if (flush) begin
      exp_q.delete();
      return;
    end
`ifdef UART_RX_FIFO_BREAK_EN
    entry = {rx_break, rx_data};
`else
    entry = {1'b0, rx_break ? 8'h00 : rx_data};
`endif
    if (do_pop) void'(exp_q.pop_front());
    if (rx_valid && (!is_full || do_pop)) exp_q.push_back(entry);
  endtask

  task automatic compare_all();
    int n;
    n = exp_q.size();
    check("rd_valid", 32'(rd_valid), 32'(n != 0));
    check("level", 32'(level), 32'(n));
    check("overrun", 32'(overrun), 32'(exp_ovr));
    check("irq", 32'(irq), 32'((n >= int'(thr)) && (thr != 0)));
    if (n != 0) begin
      check("rd_data", 32'(rd_data), 32'(exp_q[0][DB-1:0]));
      check("rd_break", 32'(rd_break), 32'(exp_q[0][DB]));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [DB-1:0] d, input logic b,
                       input logic r, input logic f, input logic c);
    rx_valid    = v;
    rx_data     = d;
    rx_break    = b;
    rd_ready    = r;
    flush       = f;
    clr_overrun = c;
    step();
  endtask

  task automatic push(input logic [DB-1:0] d);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_flush();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_ovr = 1'b0;
    resetn = 1'b0;
    thr = '0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    resetn = 1'b1;

    // Three characters in, three out, in order.
    push(8'h41); push(8'h42); push(8'h43);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_level", 32'(level), 32'd3);
    check("t1_head", 32'(rd_data), 32'h41);
    for (int i = 0; i < 3; i++) begin
      check("t1_read", 32'(rd_data), 32'(8'h41 + i));
      pop_one();
    end
    check("t1_empty", 32'(rd_valid), 32'd0);

    // Seventeen characters into a 16-deep FIFO: the last one is dropped.
    for (int i = 0; i < 17; i++) push(8'(i));
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_level", 32'(level), 32'd16);
    check("t2_overrun", 32'(overrun), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("t2_read", 32'(rd_data), 32'(i));
      pop_one();
    end
    check("t2_empty", 32'(rd_valid), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t2_clr", 32'(overrun), 32'd0);

    // Simultaneous push and pop while full.
    for (int i = 0; i < 16; i++) push(8'(i));
    drive(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t3_level", 32'(level), 32'd16);
    check("t3_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check("t3_read", 32'(rd_data), (i == 15) ? 32'hAA : 32'(i + 1));
      pop_one();
    end

    // Threshold interrupt.
    thr = 5'd4;
    push(8'h01); push(8'h02); push(8'h03);
    check("t4_irq3", 32'(irq), 32'd0);
    push(8'h04);
    check("t4_irq4", 32'(irq), 32'd1);
    pop_one();
    check("t4_irq_pop", 32'(irq), 32'd0);
    for (int i = 0; i < 13; i++) push(8'(i));
    check("t4_full", 32'(level), 32'd16);
    thr = 5'd0;
    #1;
    check("t4_thr0", 32'(irq), 32'd0);
    thr = 5'd20;
    #1;
    check("t4_thr_big", 32'(irq), 32'd0);
    thr = 5'd0;

    // Flush: discards concurrent character, leaves overrun alone.
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_full_flush_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < 17; i++) push(8'(i));
    do_flush();
    check("t5_flush_keeps_ovr", 32'(overrun), 32'd1);
    for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_level", 32'(level), 32'd0);
    check("t5_valid", 32'(rd_valid), 32'd0);
    check("t5_ovr", 32'(overrun), 32'd1);
    push(8'h66);
    check("t5_next", 32'(rd_data), 32'h66);
    pop_one();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Break characters.
    drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    push(8'h31);
`ifdef UART_RX_FIFO_BREAK_EN
    check("t6_brk1", 32'(rd_break), 32'd1);
    pop_one();
    check("t6_brk0", 32'(rd_break), 32'd0);
    check("t6_data", 32'(rd_data), 32'h31);
`else
    check("t6_data0", 32'(rd_data), 32'h00);
    check("t6_nobrk", 32'(rd_break), 32'd0);
    pop_one();
    check("t6_data1", 32'(rd_data), 32'h31);
`endif
    pop_one();

    // Randomized traffic, alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 3000; i++) begin
      int rd_pct;
      rd_pct = ((i / 200) % 2 == 0) ? 25 : 75;
      if ($urandom_range(0, 49) == 0) thr = 5'($urandom_range(0, 20));
      resetn = ($urandom_range(0, 999) != 0);
      drive($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 7) == 0,
            $urandom_range(0, 99) < rd_pct, $urandom_range(0, 99) == 0,
            $urandom_range(0, 31) == 0);
    end
    resetn = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. Captures each single-cycle valid/data (and break) pulse from the receiver into a synchronous circular FIFO and presents bytes to the CPU-side peripheral register logic over a first-word-fall-through valid/ready read port. Provides a fill level, a sticky overrun flag, and a level-threshold interrupt so software can drain in bursts.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (depth = 16 entries); legal range 1..8
DATA_BITS, 8, payload width; matches the receiver's PAYLOAD_BITS

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
rx_valid  in  1  one-cycle pulse from receiver: character complete
rx_data  in  DATA_BITS  received character; sampled when rx_valid=1
rx_break  in  1  receiver break indication; qualified by rx_valid
rd_ready  in  1  consumer pops the head entry when rd_valid=1
rd_valid  out  1  FIFO non-empty
rd_data  out  DATA_BITS  head entry data
rd_break  out  1  head entry was a break (macro only; otherwise constant 0)
flush  in  1  discard all entries
clr_overrun  in  1  clear sticky overrun
overrun  out  1  sticky: a character was dropped because the FIFO was full
level  out  DEPTH_LOG2+1  current number of stored entries, 0..2^DEPTH_LOG2
thr  in  DEPTH_LOG2+1  interrupt threshold
irq  out  1  level >= thr, with thr != 0

Behaviour:
- Reset (resetn=0 at posedge clk): write pointer, read pointer, and level = 0; overrun = 0. Hence rd_valid = 0, irq = 0. Storage array is not reset; rd_data is don't-care while rd_valid = 0.
- Pointers: DEPTH_LOG2 bits, natural binary wrap from 2^DEPTH_LOG2-1 to 0. The level counter is kept separately (DEPTH_LOG2+1 bits). Full is level == 2^DEPTH_LOG2; empty is level == 0.
- Push: occurs when rx_valid=1 and (not full, or a pop occurs in the same cycle). The entry is written at the write pointer and the write pointer increments.
- Pop: occurs when rd_valid=1 and rd_ready=1. The read pointer increments. rd_ready while empty has no effect.
- Level update: push only gives +1; pop only gives -1; push and pop together leave level unchanged.
- First-word-fall-through: rd_data and rd_break are driven combinationally from the array at the read pointer. A character pushed into an empty FIFO is visible with rd_valid=1 on the cycle after its rx_valid pulse (1-cycle latency).
- Overrun: rx_valid=1 while full with no simultaneous pop drops the character (FIFO contents unchanged) and sets overrun=1 on the next cycle.
  - clr_overrun clears overrun.
  - If a set and a clear occur in the same cycle, set wins.
- Flush: has priority over push and pop in the same cycle. Pointers and level go to 0; any concurrent rx_valid character is discarded and does not set overrun. overrun itself is unaffected by flush.
- irq: combinational (level >= thr) && (thr != 0). thr values above the depth never assert irq.
- All outputs change only on posedge clk, except rd_data, rd_break, and irq, which decode registered state combinationally.

Optional Feature:
UART_RX_FIFO_BREAK_EN
- Defined: the storage word is DATA_BITS+1 wide. rx_break is stored with each entry and returned on rd_break for that same entry.
- Undefined: the storage word is DATA_BITS wide. A break is stored as an ordinary all-zero character, and rd_break is tied to 0.

Decomposition:
- Shared package (uart_pkg): UART_DATA_BITS default, FIFO depth constant, and the entry typedef (data plus optional break bit).
- One natural sub-module, uart_fifo_mem: a register-array dual-port memory with a synchronous write port and an asynchronous read port. It is reusable for a future transmit FIFO.
- Pointer, level, and flag logic stays in the top module.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 one clock apart with rd_ready=0 -> level=3, rd_valid=1, rd_data=0x41. Pop three times -> reads 0x41, 0x42, 0x43 in order, level=0, rd_valid=0.
- Push 17 characters 0x00..0x10 with no reads -> level=16, overrun=1 after the 17th. Drain -> 0x00..0x0F (0x10 dropped). Pulse clr_overrun -> overrun=0.
- Full FIFO, rx_valid and pop in the same cycle with 0xAA -> level stays 16, overrun stays 0, 0xAA is read last.
- thr=4: push 3 -> irq=0; push 4th -> irq=1; pop 1 -> irq=0. Set thr=0 with level 16 -> irq=0.
- level=5, flush together with rx_valid(0x55) -> level=0, rd_valid=0, overrun unchanged. The next push of 0x66 reads back as 0x66.
- With UART_RX_FIFO_BREAK_EN: push a break (0x00, rx_break=1) then 0x31 -> first read has rd_break=1, second has rd_break=0. Without the macro -> first read 0x00 with rd_break=0.
